ccc_stream_decoder: RTL and testbench

Streaming Color Cell Compression (CCC) decoder. It accepts 64-bit CCC blocks one per beat in raster block order and emits decoded RGB24 pixels four per beat in raster pixel order. A ping-pong block-row buffer lets the next block row load while the current one is emitted. It replaces full-frame parallel decoding between the network/DMA block source and the frame writer, so area no longer scales with frame size.

---
 rtl/ccc_pkg.sv | 20 ++
 rtl/ccc_row_decode.sv | 27 ++
 rtl/ccc_stream_decoder.sv | 187 ++++++++++++++++++
 tb/tb_ccc_stream_decoder.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccc_pkg.sv
// Shared definitions for the Color Cell Compression (CCC) stream decoder:
// block field layout, pixel/block types and read-side FSM states.
package ccc_pkg;

    localparam int BITS_PER_PIXEL = 24;
    localparam int BITS_PER_BLOCK = 64;

    localparam int BITMAP_LSB = 0;
    localparam int C0_LSB     = 16;
    localparam int C1_LSB     = 40;

    typedef logic [BITS_PER_PIXEL-1:0] rgb_t;
    typedef logic [BITS_PER_BLOCK-1:0] ccc_block_t;

    typedef enum logic {
        IDLE,
        STREAM
    } rd_state_t;

endpackage

// File: rtl/ccc_row_decode.sv
// Combinational decode of one 4-pixel row of a CCC block: each bitmap bit
// picks color1 (set) or color0 (clear); leftmost pixel lands in the low bits.
module ccc_row_decode
    import ccc_pkg::*;
(
    input  ccc_block_t                  block,
    input  logic [1:0]                  row,
    output logic [4*BITS_PER_PIXEL-1:0] pixels
);

    logic [15:0] bitmap;
    rgb_t        color0;
    rgb_t        color1;

    assign bitmap = block[BITMAP_LSB +: 16];
    assign color0 = block[C0_LSB +: BITS_PER_PIXEL];
    assign color1 = block[C1_LSB +: BITS_PER_PIXEL];

    // NOTE: every output bit gets a default before the loop so no latch is inferred.
    always_comb begin
        pixels = '0;
        for (int c = 0; c < 4; c++) begin
            pixels[c*BITS_PER_PIXEL +: BITS_PER_PIXEL] = bitmap[{row, 2'(c)}] ? color1 : color0;
        end
    end

endmodule

// File: rtl/ccc_stream_decoder.sv
// Streaming CCC decoder: blocks arrive in raster block order into a ping-pong
// block-row buffer; each full bank is emitted as RGB24 pixel rows, 4 pixels/beat.
module ccc_stream_decoder
    import ccc_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [BITS_PER_BLOCK-1:0]   s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic [4*BITS_PER_PIXEL-1:0] m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic                        m_sof,
    output logic                        m_eol,
    output logic                        m_eof
);

    localparam int BPR   = WIDTH / 4;
    localparam int BROWS = HEIGHT / 4;
    localparam int IW    = (BPR > 1) ? $clog2(BPR) : 1;
    localparam int BW    = (BROWS > 1) ? $clog2(BROWS) : 1;

    localparam logic [IW-1:0] BLK_LAST  = IW'(BPR - 1);
    localparam logic [BW-1:0] BROW_LAST = BW'(BROWS - 1);

    // Write side
    logic [1:0]    full;
    logic          wr_bank;
    logic [IW-1:0] wr_idx;
    logic          s_hs;
    logic          wr_last;

    // Read side
    rd_state_t     state;
    rd_state_t     next_state;
    logic          rd_bank;
    logic [IW-1:0] blk;
    logic [1:0]    pix_row;
    logic [BW-1:0] brow;
    logic          advance;
    logic          issue;
    logic          rd_last;
    logic          issue_last;

    // Memory-read stage
    ccc_block_t    mem_q;
    logic          v1;
    logic [1:0]    row1;
    logic          sof1;
    logic          eol1;
    logic          eof1;
    logic [4*BITS_PER_PIXEL-1:0] row_pixels;

    ccc_block_t    bank_mem [2][BPR];

    assign s_ready = !rst && !full[wr_bank];
    assign s_hs    = s_valid && s_ready;
    assign wr_last = s_hs && (wr_idx == BLK_LAST);

    // The whole read pipeline moves in lockstep with the output register.
    assign advance    = !m_valid || m_ready;
    assign rd_last    = (pix_row == 2'd3) && (blk == BLK_LAST);
    assign issue_last = issue && rd_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank <= 1'b0;
            wr_idx  <= '0;
        end else if (s_hs) begin
            if (wr_last) begin
                wr_idx  <= '0;
                wr_bank <= ~wr_bank;
            end else begin
                wr_idx <= wr_idx + 1'b1;
            end
        end
    end

    // Set and clear always target different banks, so both may land together.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 2'b00;
        end else begin
            if (wr_last)    full[wr_bank] <= 1'b1;
            if (issue_last) full[rd_bank] <= 1'b0;
        end
    end

    // NOTE: bank storage and its read register carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (s_hs)  bank_mem[wr_bank][wr_idx] <= s_data;
        if (issue) mem_q <= bank_mem[rd_bank][blk];
    end

    // IDLE issues the first read in the same cycle it sees a full bank.
    always_comb begin
        next_state = state;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                if (full[rd_bank] && advance) begin
                    issue      = 1'b1;
                    next_state = STREAM;
                end
            end
            STREAM: begin
                if (advance) begin
                    issue = 1'b1;
                    if (rd_last && !full[!rd_bank]) next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: all clocked state uses non-blocking assignments to avoid simulation races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rd_bank <= 1'b0;
            blk     <= '0;
            pix_row <= 2'd0;
            brow    <= '0;
        end else begin
            state <= next_state;
            if (issue) begin
                if (blk == BLK_LAST) begin
                    blk     <= '0;
                    pix_row <= pix_row + 2'd1;
                    if (pix_row == 2'd3) begin
                        rd_bank <= ~rd_bank;
                        brow    <= (brow == BROW_LAST) ? '0 : brow + 1'b1;
                    end
                end else begin
                    blk <= blk + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1   <= 1'b0;
            row1 <= 2'd0;
            sof1 <= 1'b0;
            eol1 <= 1'b0;
            eof1 <= 1'b0;
        end else if (advance) begin
            v1   <= issue;
            row1 <= pix_row;
            sof1 <= (brow == '0) && (pix_row == 2'd0) && (blk == '0);
            eol1 <= (blk == BLK_LAST);
            eof1 <= (blk == BLK_LAST) && (pix_row == 2'd3) && (brow == BROW_LAST);
        end
    end

    ccc_row_decode u_row_decode (
        .block  (mem_q),
        .row    (row1),
        .pixels (row_pixels)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_sof   <= 1'b0;
            m_eol   <= 1'b0;
            m_eof   <= 1'b0;
            m_data  <= '0;
        end else if (advance) begin
            m_valid <= v1;
            m_sof   <= v1 && sof1;
            m_eol   <= v1 && eol1;
            m_eof   <= v1 && eof1;
            if (v1) m_data <= row_pixels;
        end
    end

    a_full_set_clear_distinct : assert property (
        @(posedge clk) disable iff (rst) !(wr_last && issue_last && (wr_bank == rd_bank))
    );

endmodule

// File: tb/tb_ccc_stream_decoder.sv
// Randomized self-checking bench for ccc_stream_decoder on an 8x8 frame, checked
// against a pixel-level image model derived directly from the CCC decode rule.
module tb_ccc_stream_decoder;
    import ccc_pkg::*;

    localparam int WIDTH  = 8;
    localparam int HEIGHT = 8;
    localparam int BPR    = WIDTH / 4;
    localparam int BEATS  = WIDTH * HEIGHT / 4;

    typedef struct packed {
        logic        sof;
        logic        eol;
        logic        eof;
        logic [95:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [95:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_sof;
    logic        m_eol;
    logic        m_eof;

    int n_checks = 0;
    int n_pass   = 0;

    ccc_block_t src_q[$];
    beat_t      got[$];
    beat_t      exp_q[$];
    ccc_block_t frame_blks[$];

    int          m_mode = 1;   // 0: m_ready low, 1: high, 2: random
    int          cyc = 0;
    int          n_acc = 0;
    int          acc_since_rst = 0;
    int          last_acc_cyc = 0;
    int          first_valid_cyc = -1;
    int          n_stalls = 0;
    int          stall_bad = 0;
    logic        prev_stall = 1'b0;
    logic [99:0] prev_out = '0;

    ccc_stream_decoder #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_sof   (m_sof),
        .m_eol   (m_eol),
        .m_eof   (m_eof)
    );

    always #5 clk = ~clk;

    // Source and sink drivers change inputs 2 time units after each rising edge.
    always @(posedge clk) begin
        cyc++;
        #2;
        if (src_q.size() > 0) begin
            s_valid = 1'b1;
            s_data  = src_q[0];
        end else begin
            s_valid = 1'b0;
            s_data  = '0;
        end
        m_ready = (m_mode == 2) ? 1'($urandom_range(0, 1)) : (m_mode == 1);
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_stall      = 1'b0;
            acc_since_rst   = 0;
            first_valid_cyc = -1;
        end else begin
            if (s_valid && s_ready) begin
                void'(src_q.pop_front());
                n_acc++;
                if (acc_since_rst == BPR - 1) last_acc_cyc = cyc;
                acc_since_rst++;
            end
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_stall) begin
                n_stalls++;
                if ({m_valid, m_sof, m_eol, m_eof, m_data} !== prev_out) stall_bad++;
            end
            if (m_valid && m_ready) got.push_back('{sof: m_sof, eol: m_eol, eof: m_eof, data: m_data});
            prev_stall = m_valid && !m_ready;
            prev_out   = {m_valid, m_sof, m_eol, m_eof, m_data};
        end
    end

    // Image-level model: decode every pixel of the frame, then cut it into beats.
    function automatic void model_frame(input ccc_block_t blks[$]);
        for (int y = 0; y < HEIGHT; y++) begin
            for (int bx = 0; bx < BPR; bx++) begin
                beat_t      b;
                ccc_block_t blk;
                b = '0;
                blk = blks[(y / 4) * BPR + bx];
                for (int k = 0; k < 4; k++) begin
                    b.data[k*24 +: 24] = blk[(y % 4) * 4 + k] ? blk[63:40] : blk[39:16];
                end
                b.sof = (y == 0) && (bx == 0);
                b.eol = (bx == BPR - 1);
                b.eof = b.eol && (y == HEIGHT - 1);
                exp_q.push_back(b);
            end
        end
    endfunction

    task automatic new_frame(output ccc_block_t blks[$]);
        blks = {};
        for (int i = 0; i < BPR * HEIGHT / 4; i++) blks.push_back({$urandom, $urandom});
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks += 6;
        if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b want 0", m_valid); else n_pass++;
        if (m_sof !== 1'b0)   $display("FAIL reset_m_sof: got %b want 0", m_sof);     else n_pass++;
        if (m_eol !== 1'b0)   $display("FAIL reset_m_eol: got %b want 0", m_eol);     else n_pass++;
        if (m_eof !== 1'b0)   $display("FAIL reset_m_eof: got %b want 0", m_eof);     else n_pass++;
        if (m_data !== '0)    $display("FAIL reset_m_data: got %h want 0", m_data);   else n_pass++;
        if (s_ready !== 1'b0) $display("FAIL reset_s_ready: got %b want 0", s_ready); else n_pass++;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (s_ready !== 1'b1) $display("FAIL ready_after_reset: got %b want 1", s_ready); else n_pass++;
    endtask

    task automatic test_directed();
        ccc_block_t blks[$];
        new_frame(blks);
        blks[0] = {24'hFF0000, 24'h0000FF, 16'h000F};
        got.delete();
        exp_q.delete();
        model_frame(blks);
        m_mode = 1;
        foreach (blks[i]) src_q.push_back(blks[i]);
        for (int t = 0; t < 500 && got.size() < BEATS; t++) @(negedge clk);
        n_checks += 4;
        if (got.size() != BEATS) $display("FAIL directed_count: got %0d want %0d", got.size(), BEATS); else n_pass++;
        if (got[0].data !== {4{24'hFF0000}} || got[0].sof !== 1'b1)
            $display("FAIL directed_row0: got data %h sof %b want %h sof 1", got[0].data, got[0].sof, {4{24'hFF0000}});
        else n_pass++;
        if (got[BPR].data !== {4{24'h0000FF}})
            $display("FAIL directed_row1: got %h want %h", got[BPR].data, {4{24'h0000FF}});
        else n_pass++;
        if (first_valid_cyc - last_acc_cyc != 3)
            $display("FAIL latency: got %0d want 3", first_valid_cyc - last_acc_cyc);
        else n_pass++;
        for (int i = 0; i < BEATS; i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) $display("FAIL directed_beat%0d: got %h want %h", i, got[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_frame();
        new_frame(frame_blks);
        got.delete();
        exp_q.delete();
        model_frame(frame_blks);
        m_mode = 1;
        foreach (frame_blks[i]) src_q.push_back(frame_blks[i]);
        for (int t = 0; t < 500 && got.size() < BEATS; t++) @(negedge clk);
        n_checks++;
        if (got.size() != BEATS) $display("FAIL frame_count: got %0d want %0d", got.size(), BEATS); else n_pass++;
        for (int i = 0; i < BEATS; i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) $display("FAIL frame_beat%0d: got %h want %h", i, got[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        ccc_block_t blks[$];
        new_frame(blks);
        got.delete();
        exp_q.delete();
        model_frame(frame_blks);
        model_frame(blks);
        n_stalls  = 0;
        stall_bad = 0;
        m_mode = 2;
        foreach (frame_blks[i]) src_q.push_back(frame_blks[i]);
        foreach (blks[i]) src_q.push_back(blks[i]);
        for (int t = 0; t < 2000 && got.size() < 2 * BEATS; t++) @(negedge clk);
        m_mode = 1;
        n_checks += 3;
        if (got.size() != 2 * BEATS) $display("FAIL bp_count: got %0d want %0d", got.size(), 2 * BEATS); else n_pass++;
        if (stall_bad != 0) $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_bad); else n_pass++;
        if (n_stalls == 0) $display("FAIL bp_stalled: got 0 stalls want >0"); else n_pass++;
        for (int i = 0; i < 2 * BEATS; i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) $display("FAIL bp_beat%0d: got %h want %h", i, got[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_flood();
        ccc_block_t blks_a[$];
        ccc_block_t blks_b[$];
        int         acc0;
        int         t;
        new_frame(blks_a);
        new_frame(blks_b);
        got.delete();
        exp_q.delete();
        model_frame(blks_a);
        model_frame(blks_b);
        m_mode = 0;
        @(posedge clk);
        acc0 = n_acc;
        foreach (blks_a[i]) src_q.push_back(blks_a[i]);
        foreach (blks_b[i]) src_q.push_back(blks_b[i]);
        repeat (20) @(posedge clk);
        @(negedge clk);
        n_checks += 3;
        if (n_acc - acc0 != 2 * BPR) $display("FAIL flood_accepted: got %0d want %0d", n_acc - acc0, 2 * BPR); else n_pass++;
        if (s_ready !== 1'b0) $display("FAIL flood_ready_low: got %b want 0", s_ready); else n_pass++;
        m_mode = 1;
        for (t = 0; t < 50 && s_ready !== 1'b1; t++) @(negedge clk);
        if (s_ready !== 1'b1) $display("FAIL flood_ready_rise: got %b want 1", s_ready); else n_pass++;
        for (t = 0; t < 1000 && got.size() < 2 * BEATS; t++) @(negedge clk);
        n_checks++;
        if (got.size() != 2 * BEATS) $display("FAIL flood_count: got %0d want %0d", got.size(), 2 * BEATS); else n_pass++;
        for (int i = 0; i < 2 * BEATS; i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) $display("FAIL flood_beat%0d: got %h want %h", i, got[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        ccc_block_t blks[$];
        new_frame(blks);
        got.delete();
        m_mode = 1;
        foreach (blks[i]) src_q.push_back(blks[i]);
        for (int t = 0; t < 500 && got.size() < BEATS / 2 + 2; t++) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        src_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        got.delete();
        @(negedge clk);
        n_checks++;
        if (m_valid !== 1'b0) $display("FAIL midreset_m_valid: got %b want 0", m_valid); else n_pass++;
        new_frame(blks);
        exp_q.delete();
        model_frame(blks);
        foreach (blks[i]) src_q.push_back(blks[i]);
        for (int t = 0; t < 500 && got.size() < BEATS; t++) @(negedge clk);
        n_checks += 2;
        if (got.size() != BEATS) $display("FAIL midreset_count: got %0d want %0d", got.size(), BEATS); else n_pass++;
        if (got[0].sof !== 1'b1) $display("FAIL midreset_sof: got %b want 1", got[0].sof); else n_pass++;
        for (int i = 0; i < BEATS; i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) $display("FAIL midreset_beat%0d: got %h want %h", i, got[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_frame();
        test_backpressure();
        test_flood();
        test_reset_mid();
        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
